// File: rtl/apb_bridge_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_bridge_master_if                                                  |
// | Request/response port and APB4 bus bundle for apb_bridge_master.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface apb_bridge_master_if #(
  parameter int addrw = 32,
  parameter int dataw = 32,
  parameter int NSLV  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [addrw-1:0]        req_addr;
  logic [dataw-1:0]        req_wdata;
  logic [dataw/8-1:0]      req_strb;
  logic                    rsp_valid;
  logic [dataw-1:0]        rsp_rdata;
  logic                    rsp_err;
  logic [addrw-1:0]        paddr;
  logic [NSLV-1:0]         psel;
  logic                    penable;
  logic                    pwrite;
  logic [dataw-1:0]        pwdata;
  logic [dataw/8-1:0]      pstrb;
  logic [NSLV*dataw-1:0]   prdata;
  logic [NSLV-1:0]         pready;
  logic [NSLV-1:0]         pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface
`default_nettype wire

// File: rtl/apb_bridge_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_bridge_master                                                     |
// | APB4 master: one request in, address decode, SETUP/ACCESS, one resp.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module apb_bridge_master #(
  parameter int addrw   = 32,
  parameter int dataw   = 32,
  parameter int NSLV    = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb_bridge_master_if.master bus
);
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int HI = SLV_AW + IW;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = dataw / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [dataw-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [addrw-1:0] paddr_q, paddr_d;
  logic [NSLV-1:0]  psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [dataw-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]    pstrb_q, pstrb_d;

  logic [IW-1:0]    w_idx;
  logic             w_idx_bad;
  logic             w_hi_bad;
  logic             w_dec_err;
  logic             w_ready;
  logic             w_slverr;
  logic [dataw-1:0] w_prdata;
  logic             w_timeout;

  assign w_idx = bus.req_addr[SLV_AW +: IW];

  // Index range check only exists when NSLV leaves unused codes in IW bits.
  if ((1 << IW) > NSLV) begin : g_idx_chk
    assign w_idx_bad = (w_idx >= IW'(NSLV));
  end else begin : g_idx_full
    assign w_idx_bad = 1'b0;
  end

  if (HI < addrw) begin : g_hi_chk
    assign w_hi_bad = |bus.req_addr[addrw-1:HI];
  end else begin : g_hi_none
    assign w_hi_bad = 1'b0;
  end

  assign w_dec_err = w_idx_bad | w_hi_bad;

  assign w_ready  = bus.pready[idx_q];
  assign w_slverr = bus.pslverr[idx_q];
  assign w_prdata = bus.prdata[int'(idx_q) * dataw +: dataw];

  // cnt_q counts completed ACCESS cycles; the last allowed one trips the timeout.
  if (TIMEOUT > 0) begin : g_timeout
    assign w_timeout = ((cnt_q + CW'(1)) == CW'(TIMEOUT));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          idx_d = w_idx;
          if (w_dec_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d       = SETUP;
            cnt_d         = '0;
            psel_d        = '0;
            psel_d[w_idx] = 1'b1;
            penable_d     = 1'b0;
            paddr_d       = bus.req_addr;
            pwrite_d      = bus.req_write;
            pwdata_d      = bus.req_write ? bus.req_wdata : '0;
            pstrb_d       = bus.req_write ? bus.req_strb  : '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (w_ready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = w_slverr;
          rsp_rdata_d = (!pwrite_q && !w_slverr) ? w_prdata : '0;
        end else if (w_timeout) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_bridge_master                                                  |
// | Randomized self-checking bench for apb_bridge_master.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_apb_bridge_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SAW = 12;
  localparam int TO  = 16;

  logic pclk = 1'b0;
  logic preset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_bridge_master_if #(.addrw(AW), .dataw(DW), .NSLV(NS)) bus ();

  apb_bridge_master #(
    .addrw(AW), .dataw(DW), .NSLV(NS), .SLV_AW(SAW), .TIMEOUT(TO)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  // Observations of the most recent transaction.
  int          o_lat, o_psel_cyc, o_pen_cyc, o_acc_cyc;
  logic        o_err, o_stable, o_pulse_ok, o_pwrite;
  logic [31:0] o_rdata, o_paddr, o_pwdata;
  logic [3:0]  o_psel, o_pstrb;

  // Reference: expected outcome from address map, slave wait count and error.
  function automatic void model(input logic wr, input logic [31:0] addr, input int wait_n,
                                input logic serr, input logic [31:0] rdat,
                                output int e_lat, output logic e_err, output logic [31:0] e_rdata,
                                output logic [3:0] e_psel, output int e_pen);
    if (addr >= 32'(NS << SAW)) begin
      e_lat = 1; e_err = 1'b1; e_rdata = '0; e_psel = '0; e_pen = 0;
    end else if (TO != 0 && wait_n >= TO) begin
      e_lat = TO + 2; e_err = 1'b1; e_rdata = '0; e_psel = 4'(1) << (addr >> SAW); e_pen = TO;
    end else begin
      e_lat = 3 + wait_n; e_err = serr; e_rdata = (!wr && !serr) ? rdat : '0;
      e_psel = 4'(1) << (addr >> SAW); e_pen = wait_n + 1;
    end
  endfunction

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int wait_n, input logic serr,
                         input logic [31:0] rdat);
    int   a, k, idx;
    logic first;
    idx = (addr < 32'(NS << SAW)) ? int'(addr >> SAW) : -1;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin @(negedge pclk); k++; end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_strb = strb;
    @(posedge pclk);
    o_acc_cyc = cyc;
    @(negedge pclk);
    bus.req_valid = 1'b0; bus.req_write = 1'($urandom); bus.req_addr = $urandom;
    bus.req_wdata = $urandom; bus.req_strb = 4'($urandom);
    o_lat = -1; o_err = 1'b0; o_rdata = '0; o_psel = '0; o_paddr = '0; o_pwdata = '0;
    o_pstrb = '0; o_pwrite = 1'b0; o_psel_cyc = 0; o_pen_cyc = 0; o_stable = 1'b1;
    o_pulse_ok = 1'b0; first = 1'b1; a = 0;
    for (k = 1; k <= 60; k++) begin
      if (bus.psel !== '0) begin
        o_psel_cyc++;
        if (first) begin
          o_psel = bus.psel; o_paddr = bus.paddr; o_pwdata = bus.pwdata;
          o_pstrb = bus.pstrb; o_pwrite = bus.pwrite; first = 1'b0;
        end else if (bus.psel !== o_psel || bus.paddr !== o_paddr || bus.pwdata !== o_pwdata ||
                     bus.pstrb !== o_pstrb || bus.pwrite !== o_pwrite) begin
          o_stable = 1'b0;
        end
      end
      if (bus.penable === 1'b1) o_pen_cyc++;
      if (bus.rsp_valid === 1'b1) begin
        o_lat = k; o_err = bus.rsp_err; o_rdata = bus.rsp_rdata;
        break;
      end
      bus.pready  = 4'($urandom);
      bus.pslverr = 4'($urandom);
      bus.prdata  = {$urandom, $urandom, $urandom, $urandom};
      if (idx >= 0 && bus.penable === 1'b1) begin
        a++;
        bus.pready[idx]            = (a > wait_n);
        bus.pslverr[idx]           = serr;
        bus.prdata[idx*DW +: DW]   = rdat;
      end
      @(negedge pclk);
    end
    if (o_lat > 0) begin
      @(negedge pclk);
      o_pulse_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    total++; if (bus.psel !== '0 || bus.penable !== 1'b0) begin bad++; $display("FAIL reset_psel got=%b/%b exp=0/0", bus.psel, bus.penable); end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin
      bad++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    total++; if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.pstrb !== '0 || bus.pwrite !== 1'b0) begin
      bad++; $display("FAIL reset_apb got=%h/%h/%h/%b exp=0", bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite); end
    preset = 1'b0;
    @(negedge pclk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 32'h1004, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h1234_5678);
    total++; if (o_psel !== 4'b0010) begin bad++; $display("FAIL wr_psel got=%b exp=0010", o_psel); end
    total++; if (o_paddr !== 32'h1004 || o_pwrite !== 1'b1) begin bad++; $display("FAIL wr_paddr got=%h/%b exp=1004/1", o_paddr, o_pwrite); end
    total++; if (o_pstrb !== 4'hF || o_pwdata !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_data got=%h/%h exp=f/a5a50001", o_pstrb, o_pwdata); end
    total++; if (o_lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", o_lat); end
    total++; if (o_err !== 1'b0 || o_rdata !== '0) begin bad++; $display("FAIL wr_rsp got=%b/%h exp=0/0", o_err, o_rdata); end
    total++; if (o_pen_cyc !== 1 || !o_pulse_ok) begin bad++; $display("FAIL wr_pen_pulse got=%0d/%b exp=1/1", o_pen_cyc, o_pulse_ok); end
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 32'h3010, 32'hFFFF_FFFF, 4'hF, 2, 1'b0, 32'hDEAD_BEEF);
    total++; if (o_psel !== 4'b1000 || o_psel_cyc !== 4) begin bad++; $display("FAIL rd_psel got=%b x%0d exp=1000 x4", o_psel, o_psel_cyc); end
    total++; if (o_pen_cyc !== 3) begin bad++; $display("FAIL rd_penable got=%0d exp=3", o_pen_cyc); end
    total++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin bad++; $display("FAIL rd_rdata got=%h/%b exp=deadbeef/0", o_rdata, o_err); end
    total++; if (o_lat !== 5) begin bad++; $display("FAIL rd_latency got=%0d exp=5", o_lat); end
    total++; if (o_pstrb !== '0 || o_pwdata !== '0 || !o_stable) begin bad++; $display("FAIL rd_strb got=%h/%h/%b exp=0/0/1", o_pstrb, o_pwdata, o_stable); end
  endtask

  task automatic test_slverr();
    run_txn(1'b0, 32'h0020, 32'h0, 4'h0, 1, 1'b1, 32'hCAFE_F00D);
    total++; if (o_err !== 1'b1 || o_rdata !== '0) begin bad++; $display("FAIL slverr_rsp got=%b/%h exp=1/0", o_err, o_rdata); end
    total++; if (o_psel !== 4'b0001 || o_lat !== 4) begin bad++; $display("FAIL slverr_sel got=%b/%0d exp=0001/4", o_psel, o_lat); end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_4000; addrs[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, addrs[i], 32'h0, 4'h0, 0, 1'b0, 32'h1111_1111);
      total++; if (o_psel_cyc !== 0) begin bad++; $display("FAIL dec_psel addr=%h got=%0d cycles exp=0", addrs[i], o_psel_cyc); end
      total++; if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== '0) begin
        bad++; $display("FAIL dec_rsp addr=%h got=%0d/%b/%h exp=1/1/0", addrs[i], o_lat, o_err, o_rdata); end
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h2000, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA);
    total++; if (o_pen_cyc !== TO) begin bad++; $display("FAIL to_penable got=%0d exp=%0d", o_pen_cyc, TO); end
    total++; if (o_err !== 1'b1 || o_rdata !== '0 || o_lat !== TO + 2) begin
      bad++; $display("FAIL to_rsp got=%b/%h/%0d exp=1/0/%0d", o_err, o_rdata, o_lat, TO + 2); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    bus.pready = '0; bus.pslverr = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h2008;
    @(posedge pclk);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge pclk);
    total++; if (bus.penable !== 1'b1 || bus.psel !== 4'b0100) begin bad++; $display("FAIL mid_access got=%b/%b exp=1/0100", bus.penable, bus.psel); end
    preset = 1'b1;
    @(negedge pclk);
    total++; if (bus.psel !== '0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%b exp=0/0/0", bus.psel, bus.penable, bus.rsp_valid); end
    preset = 1'b0;
    @(negedge pclk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", bus.req_ready); end
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid === 1'b1 || bus.psel !== '0) seen = 1'b1;
      @(negedge pclk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int c0;
    run_txn(1'b1, 32'h0100, 32'h0BAD_0001, 4'h3, 0, 1'b0, 32'h0);
    c0 = o_acc_cyc;
    run_txn(1'b0, 32'h1200, 32'h0, 4'h0, 0, 1'b0, 32'h7777_0002);
    total++; if (o_acc_cyc - c0 !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d exp=4", o_acc_cyc - c0); end
    total++; if (o_rdata !== 32'h7777_0002 || o_psel !== 4'b0010) begin
      bad++; $display("FAIL b2b_second got=%h/%b exp=77770002/0010", o_rdata, o_psel); end
  endtask

  task automatic test_random();
    logic        wr, serr;
    logic [31:0] addr, wdata, rdat, e_rdata;
    logic [3:0]  strb, e_psel;
    int          w, e_lat, e_pen;
    logic        e_err;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); serr = ($urandom_range(0, 3) == 0);
      wdata = $urandom; rdat = $urandom; strb = 4'($urandom);
      if ($urandom_range(0, 7) == 0) addr = 32'h4000 + ($urandom & 32'h7FFF_FFFC);
      else addr = (32'($urandom_range(0, NS - 1)) << SAW) | ($urandom & 32'hFFC);
      w = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
      model(wr, addr, w, serr, rdat, e_lat, e_err, e_rdata, e_psel, e_pen);
      run_txn(wr, addr, wdata, strb, w, serr, rdat);
      total++; if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata) begin
        bad++; $display("FAIL rnd_rsp n=%0d got=%0d/%b/%h exp=%0d/%b/%h", n, o_lat, o_err, o_rdata, e_lat, e_err, e_rdata); end
      total++; if (o_psel !== e_psel || o_pen_cyc !== e_pen || !o_stable || !o_pulse_ok) begin
        bad++; $display("FAIL rnd_bus n=%0d got=%b/%0d/%b/%b exp=%b/%0d/1/1", n, o_psel, o_pen_cyc, o_stable, o_pulse_ok, e_psel, e_pen); end
      if (e_psel !== '0) begin
        total++; if (o_paddr !== addr || o_pwrite !== wr || o_pstrb !== (wr ? strb : 4'h0) ||
                     o_pwdata !== (wr ? wdata : 32'h0)) begin
          bad++; $display("FAIL rnd_apb n=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", n, o_paddr, o_pwrite, o_pstrb, o_pwdata,
                          addr, wr, wr ? strb : 4'h0, wr ? wdata : 32'h0); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0;
    bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
    preset = 1'b1;
    @(negedge pclk);
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_decode_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/apb_bridge_master.md
# apb_bridge_master

Parametrised APB4 master bridge for the APB test environment. Accepts single read/write requests on a valid/ready port, decodes the address onto one of NSLV slave selects, and runs a full SETUP/ACCESS transfer with pready wait states, pslverr and pstrb. Returns one response per request and adds decode-error and wait-state timeout handling. It is the synthesizable master that the APB monitor and slave models sit against.

## Interface
Parameters:
- addrw, 32, address width (paddr, req_addr)
- dataw, 32, data width; must be a multiple of 8
- NSLV, 4, number of slaves, ≥1
- SLV_AW, 12, log2 of bytes per slave window
- TIMEOUT, 16, maximum ACCESS cycles without pready; 0 disables timeout

Ports:
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  addrw  byte address
- req_wdata  in  dataw  write data
- req_strb  in  dataw/8  write byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  dataw  read data
- rsp_err  out  1  slave error, decode error or timeout
- paddr  out  addrw  APB address
- psel  out  NSLV  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  dataw  APB write data
- pstrb  out  dataw/8  APB strobes
- prdata  in  NSLV*dataw  per-slave read data; slave i at [i*dataw +: dataw]
- pready  in  NSLV  per-slave ready
- pslverr  in  NSLV  per-slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- Decode:
  - idx = req_addr[SLV_AW +: IW], where IW = max(1, $clog2(NSLV)).
  - Decode error if idx ≥ NSLV, or if any req_addr bit at or above SLV_AW+IW is nonzero.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Valid decode: go to SETUP.
  - Decode error: go to RESP with rsp_err=1 and no APB activity.
- SETUP (one cycle): psel[idx]=1, penable=0; paddr/pwrite/pwdata/pstrb driven from the latch. Next state ACCESS.
- ACCESS: penable=1; wait counter increments each cycle.
  - pready[idx]=1: capture prdata slice and pslverr[idx], drop psel/penable, go to RESP.
  - TIMEOUT≠0 and counter reaches TIMEOUT with no pready: drop psel/penable, rsp_err=1, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- rsp_rdata: captured prdata on a successful read; 0 on writes and on any error.
- Reads: pstrb=0 and pwdata=0.
- Only psel[idx] is ever asserted. psel, penable and the APB address/data stay stable from SETUP through the end of ACCESS.
- pready/prdata/pslverr of unselected slaves are ignored.

## Timing
- Reset values: req_ready=0 while preset is high, then 1 (IDLE). All other outputs are 0.
- preset asserted mid-transfer: psel/penable go to 0 at the next edge. No response is emitted for the aborted request.
- Request accepted at edge E0. SETUP is visible E0→E1, ACCESS from E1.
- Zero-wait slave (pready=1 in first ACCESS cycle): rsp_valid high in the cycle after E2. Request-to-response latency is 3 cycles, plus 1 per wait state.
- Decode error: rsp_valid in the cycle after E0 (1-cycle latency).
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then RESP.
- Throughput: back-to-back requests are accepted every 4 cycles minimum (IDLE→SETUP→ACCESS→RESP→IDLE).
- Counter width is $clog2(TIMEOUT+1). The counter clears on entry to SETUP.

## Test plan
- Zero-wait write: addr 0x1004, wdata 0xA5A5_0001, strb 0xF, NSLV=4 → psel=0b0010, paddr=0x1004, pstrb=0xF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: addr 0x3010, slave 3 returns prdata 0xDEAD_BEEF → psel=0b1000 for 4 cycles, penable for 3; rsp_rdata=0xDEAD_BEEF, latency 5, pstrb=0.
- Slave error: slave 0 responds pslverr=1 on a read → rsp_err=1, rsp_rdata=0.
- Decode error: addr 0x4000 and addr 0x8000_0000 → no psel asserted; rsp_valid next cycle with rsp_err=1.
- Timeout and reset:
  - TIMEOUT=16, slave never readies → penable high exactly 16 cycles, then rsp_err=1.
  - Repeat with preset pulsed mid-ACCESS → psel=0 next edge, no rsp_valid, req_ready=1 after reset.
